// File: rtl/fu_sched_pkg.sv
// Shared definitions for the FU writeback scheduler: FU ids, default
// latency/pipeline tables and the reservation-slot entry type.
package fu_sched_pkg;

   localparam logic [2:0] FU_NONE = 3'd0;
   localparam logic [2:0] FU_ALU  = 3'd1;
   localparam logic [2:0] FU_MEM  = 3'd2;
   localparam logic [2:0] FU_MUL  = 3'd3;
   localparam logic [2:0] FU_DIV  = 3'd4;
   localparam logic [2:0] FU_JUMP = 3'd5;

   // Widest FU id a slot entry can carry; FU_W of the top must not exceed it.
   localparam int MAX_FU_W = 4;

   localparam logic [24:0] DEF_FU_LAT  = {5'd2, 5'd24, 5'd7, 5'd2, 5'd1};
   localparam logic [4:0]  DEF_FU_PIPE = 5'b00100;

   typedef struct packed {
      logic                valid;
      logic [MAX_FU_W-1:0] fu;
      logic [4:0]          rd;
   } slot_entry_t;

endpackage

// File: rtl/fu_wb_scoreboard_if.sv
// ID-side issue request and scoreboard status/writeback bundle.
interface fu_wb_scoreboard_if #(
   parameter int NUM_FU = 5,
   parameter int FU_W   = 3
);
   logic              issue_valid;
   logic [FU_W-1:0]   issue_fu;
   logic [4:0]        issue_rd;
   logic              issue_rd_used;
   logic [4:0]        issue_rs1;
   logic [4:0]        issue_rs2;
   logic              issue_rs1_used;
   logic              issue_rs2_used;
   logic              flush;
   logic              issue_ready;
   logic [3:0]        stall_cause;
   logic [NUM_FU-1:0] fu_busy;
   logic [31:0]       pending_regs;
   logic              wb_valid;
   logic [FU_W-1:0]   wb_fu;
   logic [4:0]        wb_rd;

   modport master (
      output issue_valid, issue_fu, issue_rd, issue_rd_used,
             issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used, flush,
      input  issue_ready, stall_cause, fu_busy, pending_regs,
             wb_valid, wb_fu, wb_rd
   );

   modport slave (
      input  issue_valid, issue_fu, issue_rd, issue_rd_used,
             issue_rs1, issue_rs2, issue_rs1_used, issue_rs2_used, flush,
      output issue_ready, stall_cause, fu_busy, pending_regs,
             wb_valid, wb_fu, wb_rd
   );
endinterface

// File: rtl/wb_slot_shifter.sv
// Writeback reservation array: every entry moves one slot closer to WB per
// cycle; one indexed insert per cycle overrides the shifted-in value.
module wb_slot_shifter
   import fu_sched_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ins_valid,
   input  logic [IDX_W-1:0] ins_idx,
   input  slot_entry_t      ins_entry,
   output logic [DEPTH-1:0] slot_valid,
   output slot_entry_t      head
);

   slot_entry_t slot_q [DEPTH];
   slot_entry_t slot_d [DEPTH];

   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++) begin
         slot_d[i] = slot_q[i + 1];
      end
      slot_d[DEPTH - 1] = '0;
      if (ins_valid) begin
         slot_d[ins_idx] = ins_entry;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '{default: '0};
      end else begin
         slot_q <= slot_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign slot_valid[gi] = slot_q[gi].valid;
   end

   assign head = slot_q[0];

endmodule

// File: rtl/fu_wb_scoreboard.sv
// Issue-hazard check and writeback-port scheduler between ID and the FU array:
// per-register pending table, per-FU busy table and a latency-indexed slot ring.
module fu_wb_scoreboard
   import fu_sched_pkg::*;
#(
   parameter int                NUM_FU  = 5,
   parameter int                FU_W    = 3,
   parameter int                DEPTH   = 32,
   parameter logic [5*NUM_FU-1:0] FU_LAT  = DEF_FU_LAT,
   parameter logic [NUM_FU-1:0]   FU_PIPE = DEF_FU_PIPE
) (
   input logic              clk,
   input logic              rst,
   fu_wb_scoreboard_if.slave bus
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (NUM_FU >= (1 << FU_W)) begin : g_bad_fu_w
      $error("fu_wb_scoreboard: NUM_FU does not fit in FU_W");
   end
   if (FU_W > MAX_FU_W) begin : g_bad_entry_w
      $error("fu_wb_scoreboard: FU_W wider than slot entry fu field");
   end

   logic [4:0] lat_tab [NUM_FU];
   for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_lat
      assign lat_tab[gi] = FU_LAT[gi*5 +: 5];
      if (FU_LAT[gi*5 +: 5] < 1 || FU_LAT[gi*5 +: 5] > DEPTH) begin : g_bad_lat
         $error("fu_wb_scoreboard: FU latency outside 1..DEPTH");
      end
   end

   logic [31:0]       pending_q, pending_d;
   logic [NUM_FU-1:0] fu_busy_q, fu_busy_d;

   logic              fu_ok, pipe_sel, busy_sel;
   logic [4:0]        lat;
   logic              haz_struct, haz_raw, haz_waw, haz_slot;
   logic [3:0]        stall;
   logic              ready, fire;
   logic [4:0]        rd_eff;
   logic [DEPTH-1:0]  slot_valid;
   slot_entry_t       head, ins_entry;
   logic [IDX_W-1:0]  ins_idx;

   // Decode the target FU; ids 0 and above NUM_FU never hazard and never fire.
   always_comb begin
      fu_ok    = 1'b0;
      lat      = 5'd1;
      pipe_sel = 1'b0;
      busy_sel = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (bus.issue_fu == FU_W'(i + 1)) begin
            fu_ok    = 1'b1;
            lat      = lat_tab[i];
            pipe_sel = FU_PIPE[i];
            busy_sel = fu_busy_q[i];
         end
      end
   end

   always_comb begin
      haz_struct = busy_sel & ~pipe_sel;
      haz_raw    = (bus.issue_rs1_used && bus.issue_rs1 != 5'd0 && pending_q[bus.issue_rs1]) ||
                   (bus.issue_rs2_used && bus.issue_rs2 != 5'd0 && pending_q[bus.issue_rs2]);
      haz_waw    = bus.issue_rd_used && bus.issue_rd != 5'd0 && pending_q[bus.issue_rd];
      // slot[L] shifts into slot[L-1] at the same edge the new op lands there.
      haz_slot   = (int'(lat) < DEPTH) && slot_valid[IDX_W'(lat)];
      stall      = fu_ok ? {haz_slot, haz_waw, haz_raw, haz_struct} : 4'b0000;
      ready      = ~bus.flush & ~(|stall);
      fire       = bus.issue_valid & ready & fu_ok;
      rd_eff     = bus.issue_rd_used ? bus.issue_rd : 5'd0;
      ins_idx    = IDX_W'(lat - 5'd1);
      ins_entry  = '{valid: 1'b1, fu: MAX_FU_W'(bus.issue_fu), rd: rd_eff};
   end

   wb_slot_shifter #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_slots (
      .clk        (clk),
      .rst        (rst),
      .ins_valid  (fire),
      .ins_idx    (ins_idx),
      .ins_entry  (ins_entry),
      .slot_valid (slot_valid),
      .head       (head)
   );

   // Retire clears first so a same-edge set wins.
   always_comb begin
      pending_d = pending_q;
      fu_busy_d = fu_busy_q;
      if (head.valid) begin
         pending_d[head.rd] = 1'b0;
      end
      if (fire && rd_eff != 5'd0) begin
         pending_d[rd_eff] = 1'b1;
      end
      pending_d[0] = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (head.valid && head.fu == MAX_FU_W'(i + 1)) begin
            fu_busy_d[i] = 1'b0;
         end
         if (fire && !pipe_sel && bus.issue_fu == FU_W'(i + 1)) begin
            fu_busy_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         fu_busy_q <= '0;
      end else begin
         pending_q <= pending_d;
         fu_busy_q <= fu_busy_d;
      end
   end

   assign bus.issue_ready  = ready;
   assign bus.stall_cause  = stall;
   assign bus.fu_busy      = fu_busy_q;
   assign bus.pending_regs = pending_q;
   assign bus.wb_valid     = head.valid;
   assign bus.wb_fu        = FU_W'(head.fu);
   assign bus.wb_rd        = head.rd;

endmodule

// File: tb/tb_fu_wb_scoreboard.sv
// Bench for fu_wb_scoreboard: directed vector table, hand-written DIV/reset
// sequences, then random issue traffic against an absolute-time op-list model.
module tb_fu_wb_scoreboard;
   import fu_sched_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fu_wb_scoreboard_if #(.NUM_FU(5), .FU_W(3)) bus ();

   fu_wb_scoreboard #(
      .NUM_FU  (5),
      .FU_W    (3),
      .DEPTH   (32),
      .FU_LAT  (DEF_FU_LAT),
      .FU_PIPE (DEF_FU_PIPE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference tables indexed by FU id (0 unused).
   int ref_lat  [6] = '{0, 1, 2, 7, 24, 2};
   int ref_pipe [6] = '{0, 0, 0, 1, 0, 0};

   typedef struct {
      logic       v;
      logic [2:0] fu;
      logic [4:0] rd;
      logic       rdu;
      logic [4:0] rs1;
      logic       r1u;
      logic       fl;
      logic       ready;
      logic [3:0] stall;
      logic       wbv;
      logic [2:0] wbfu;
      logic [4:0] wbrd;
   } vec_t;

   vec_t tbl [32];

   typedef struct {
      int fu;
      int rd;
      int ret;
   } op_t;

   op_t inflight [$];
   int  now;

   // Per-cycle scratch for the random phase.
   logic        r_v, r_rdu, r_r1u, r_r2u, r_fl;
   logic [2:0]  r_fu;
   logic [4:0]  r_rd, r_rs1, r_rs2;
   logic [31:0] e_pend;
   logic [4:0]  e_busy;
   logic        e_wbv, e_ready;
   logic [3:0]  e_stall;
   int          e_wbfu, e_wbrd, e_lat;
   int          wb_seen;

   function automatic vec_t mk(input int v, input int fu, input int rd, input int rdu,
                               input int rs1, input int r1u, input int fl,
                               input int ready, input int stall,
                               input int wbv, input int wbfu, input int wbrd);
      vec_t r;
      r.v = v[0]; r.fu = fu[2:0]; r.rd = rd[4:0]; r.rdu = rdu[0];
      r.rs1 = rs1[4:0]; r.r1u = r1u[0]; r.fl = fl[0];
      r.ready = ready[0]; r.stall = stall[3:0];
      r.wbv = wbv[0]; r.wbfu = wbfu[2:0]; r.wbrd = wbrd[4:0];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] fu, input logic [4:0] rd,
                        input logic rdu, input logic [4:0] rs1, input logic r1u,
                        input logic [4:0] rs2, input logic r2u, input logic fl);
      bus.issue_valid    = v;
      bus.issue_fu       = fu;
      bus.issue_rd       = rd;
      bus.issue_rd_used  = rdu;
      bus.issue_rs1      = rs1;
      bus.issue_rs1_used = r1u;
      bus.issue_rs2      = rs2;
      bus.issue_rs2_used = r2u;
      bus.flush          = fl;
   endtask

   task automatic idle();
      drive(1'b0, FU_NONE, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench 1 time unit after an edge with reset released: cycle 0.
   task automatic do_reset(input string tag);
      idle();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      check({tag, ".rst_wb_valid"}, 32'(bus.wb_valid), 32'd0);
      check({tag, ".rst_wb_fu"}, 32'(bus.wb_fu), 32'd0);
      check({tag, ".rst_wb_rd"}, 32'(bus.wb_rd), 32'd0);
      check({tag, ".rst_fu_busy"}, 32'(bus.fu_busy), 32'd0);
      check({tag, ".rst_pending"}, bus.pending_regs, 32'd0);
      rst = 1'b0;
   endtask

   initial begin : main
      idle();

      // ---------------- directed vector table ----------------
      tbl[0]  = mk(1, FU_ALU, 5, 1, 0, 0, 0,  1, 4'b0000, 0, 0, 0);
      tbl[1]  = mk(1, FU_ALU, 6, 1, 5, 1, 0,  0, 4'b0011, 1, FU_ALU, 5);
      tbl[2]  = mk(1, FU_ALU, 6, 1, 5, 1, 0,  1, 4'b0000, 0, 0, 0);
      tbl[3]  = mk(1, FU_MUL, 1, 1, 0, 0, 0,  1, 4'b0000, 1, FU_ALU, 6);
      tbl[4]  = mk(1, FU_MUL, 2, 1, 0, 0, 0,  1, 4'b0000, 0, 0, 0);
      tbl[5]  = mk(1, FU_MUL, 3, 1, 0, 0, 0,  1, 4'b0000, 0, 0, 0);
      tbl[6]  = mk(1, FU_ALU, 1, 1, 0, 0, 0,  0, 4'b0100, 0, 0, 0);
      tbl[7]  = mk(1, FU_ALU, 1, 1, 0, 0, 0,  0, 4'b0100, 0, 0, 0);
      tbl[8]  = mk(1, FU_ALU, 1, 1, 0, 0, 0,  0, 4'b0100, 0, 0, 0);
      tbl[9]  = mk(1, FU_ALU, 1, 1, 0, 0, 0,  0, 4'b1100, 0, 0, 0);
      tbl[10] = mk(1, FU_ALU, 1, 1, 0, 0, 0,  0, 4'b1100, 1, FU_MUL, 1);
      tbl[11] = mk(1, FU_ALU, 1, 1, 0, 0, 0,  0, 4'b1000, 1, FU_MUL, 2);
      tbl[12] = mk(1, FU_ALU, 1, 1, 0, 0, 0,  1, 4'b0000, 1, FU_MUL, 3);
      tbl[13] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 1, FU_ALU, 1);
      tbl[14] = mk(1, FU_ALU, 7, 1, 0, 0, 1,  0, 4'b0000, 0, 0, 0);
      tbl[15] = mk(1, FU_MEM, 8, 1, 0, 0, 0,  1, 4'b0000, 0, 0, 0);
      tbl[16] = mk(1, FU_JUMP, 9, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
      tbl[17] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 1, FU_MEM, 8);
      tbl[18] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 1, FU_JUMP, 9);
      tbl[19] = mk(1, FU_MUL, 10, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
      tbl[20] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
      tbl[21] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
      tbl[22] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
      tbl[23] = mk(1, FU_ALU, 12, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
      tbl[24] = mk(1, FU_MEM, 11, 1, 0, 0, 0, 0, 4'b1000, 1, FU_ALU, 12);
      tbl[25] = mk(1, FU_MEM, 11, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
      tbl[26] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 1, FU_MUL, 10);
      tbl[27] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 1, FU_MEM, 11);
      tbl[28] = mk(1, FU_ALU, 0, 1, 0, 0, 0,  1, 4'b0000, 0, 0, 0);
      tbl[29] = mk(1, FU_JUMP, 13, 0, 0, 0, 0, 1, 4'b0000, 1, FU_ALU, 0);
      tbl[30] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0);
      tbl[31] = mk(0, FU_NONE, 0, 0, 0, 0, 0, 1, 4'b0000, 1, FU_JUMP, 0);

      do_reset("tbl");
      for (int i = 0; i < 32; i++) begin
         drive(tbl[i].v, tbl[i].fu, tbl[i].rd, tbl[i].rdu, tbl[i].rs1, tbl[i].r1u,
               5'd0, 1'b0, tbl[i].fl);
         #1;
         check($sformatf("tbl%0d.ready", i), 32'(bus.issue_ready), 32'(tbl[i].ready));
         check($sformatf("tbl%0d.stall", i), 32'(bus.stall_cause), 32'(tbl[i].stall));
         check($sformatf("tbl%0d.wb_valid", i), 32'(bus.wb_valid), 32'(tbl[i].wbv));
         if (tbl[i].wbv) begin
            check($sformatf("tbl%0d.wb_fu", i), 32'(bus.wb_fu), 32'(tbl[i].wbfu));
            check($sformatf("tbl%0d.wb_rd", i), 32'(bus.wb_rd), 32'(tbl[i].wbrd));
         end
         if (i >= 29) begin
            check($sformatf("tbl%0d.pending_x0_only", i), bus.pending_regs, 32'd0);
         end
         next_cycle();
      end

      // ---------------- DIV: non-pipelined busy window ----------------
      do_reset("div");
      drive(1'b1, FU_DIV, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      check("div.first_ready", 32'(bus.issue_ready), 32'd1);
      next_cycle();
      for (int c = 1; c <= 24; c++) begin
         drive(1'b1, FU_DIV, 5'd21, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
         #1;
         check($sformatf("div.c%0d.stall", c), 32'(bus.stall_cause), 32'b0001);
         check($sformatf("div.c%0d.fu_busy", c), 32'(bus.fu_busy), 32'b01000);
         check($sformatf("div.c%0d.wb_valid", c), 32'(bus.wb_valid), (c == 24) ? 32'd1 : 32'd0);
         next_cycle();
      end
      drive(1'b1, FU_DIV, 5'd21, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      check("div.c25.ready", 32'(bus.issue_ready), 32'd1);
      check("div.c25.fu_busy", 32'(bus.fu_busy), 32'd0);
      check("div.c25.pending", bus.pending_regs, 32'd0);
      next_cycle();
      idle();
      #1;
      check("div.c26.fu_busy", 32'(bus.fu_busy), 32'b01000);
      check("div.c26.pending", bus.pending_regs, 32'h0020_0000);

      // ---------------- asynchronous reset with DIV in flight ----------------
      do_reset("arst");
      drive(1'b1, FU_DIV, 5'd20, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      next_cycle();
      idle();
      next_cycle();
      next_cycle();
      check("arst.pre_busy", 32'(bus.fu_busy), 32'b01000);
      check("arst.pre_pending", bus.pending_regs, 32'h0010_0000);
      #2;
      rst = 1'b1;
      #1;
      check("arst.wb_valid", 32'(bus.wb_valid), 32'd0);
      check("arst.fu_busy", 32'(bus.fu_busy), 32'd0);
      check("arst.pending", bus.pending_regs, 32'd0);
      check("arst.wb_rd", 32'(bus.wb_rd), 32'd0);
      #1;
      rst = 1'b0;
      wb_seen = 0;
      for (int c = 0; c < 30; c++) begin
         next_cycle();
         if (bus.wb_valid) wb_seen++;
      end
      check("arst.no_wb_after", 32'(wb_seen), 32'd0);

      // ---------------- random traffic vs. op-list model ----------------
      do_reset("rnd");
      inflight.delete();
      now = 0;
      for (int k = 0; k < 1500; k++) begin
         r_v   = ($urandom_range(0, 9) < 7);
         r_fu  = 3'($urandom_range(0, 5));
         r_rd  = 5'($urandom_range(0, 7));
         r_rdu = 1'($urandom_range(0, 3) != 0);
         r_rs1 = 5'($urandom_range(0, 7));
         r_r1u = 1'($urandom_range(0, 1));
         r_rs2 = 5'($urandom_range(0, 7));
         r_r2u = 1'($urandom_range(0, 1));
         r_fl  = ($urandom_range(0, 19) == 0);
         drive(r_v, r_fu, r_rd, r_rdu, r_rs1, r_r1u, r_rs2, r_r2u, r_fl);
         #1;

         e_pend = '0;
         e_busy = '0;
         e_wbv  = 1'b0;
         e_wbfu = 0;
         e_wbrd = 0;
         foreach (inflight[j]) begin
            if (inflight[j].rd != 0) e_pend[inflight[j].rd] = 1'b1;
            if (ref_pipe[inflight[j].fu] == 0) e_busy[inflight[j].fu - 1] = 1'b1;
            if (inflight[j].ret == now) begin
               e_wbv  = 1'b1;
               e_wbfu = inflight[j].fu;
               e_wbrd = inflight[j].rd;
            end
         end
         e_stall = 4'b0000;
         e_lat   = ref_lat[r_fu];
         if (r_fu != 3'd0) begin
            e_stall[0] = e_busy[r_fu - 1] && (ref_pipe[r_fu] == 0);
            e_stall[1] = (r_r1u && r_rs1 != 0 && e_pend[r_rs1]) ||
                         (r_r2u && r_rs2 != 0 && e_pend[r_rs2]);
            e_stall[2] = r_rdu && r_rd != 0 && e_pend[r_rd];
            foreach (inflight[j]) begin
               if (e_lat < 32 && inflight[j].ret == now + e_lat) e_stall[3] = 1'b1;
            end
         end
         e_ready = !r_fl && (e_stall == 4'b0000);

         check($sformatf("rnd%0d.ready", k), 32'(bus.issue_ready), 32'(e_ready));
         check($sformatf("rnd%0d.stall", k), 32'(bus.stall_cause), 32'(e_stall));
         check($sformatf("rnd%0d.fu_busy", k), 32'(bus.fu_busy), 32'(e_busy));
         check($sformatf("rnd%0d.pending", k), bus.pending_regs, e_pend);
         check($sformatf("rnd%0d.wb_valid", k), 32'(bus.wb_valid), 32'(e_wbv));
         if (e_wbv) begin
            check($sformatf("rnd%0d.wb_fu", k), 32'(bus.wb_fu), 32'(e_wbfu));
            check($sformatf("rnd%0d.wb_rd", k), 32'(bus.wb_rd), 32'(e_wbrd));
         end

         @(posedge clk);
         if (r_v && e_ready && r_fu != 3'd0) begin
            inflight.push_back('{fu: int'(r_fu), rd: (r_rdu ? int'(r_rd) : 0), ret: now + e_lat});
         end
         for (int j = inflight.size() - 1; j >= 0; j--) begin
            if (inflight[j].ret == now) inflight.delete(j);
         end
         now++;
         #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
